phy_reset_sequencer: RTL

- Single-clock sequencer for the Ethernet PHY/transceiver bring-up: PLL reset, then transceiver TX/RX reset, then MAC reset, then link-ready.
- Status inputs from the PLL and transceiver arrive asynchronously and are resynchronised internally through two-flop synchronizers before the FSM uses them.
- Adds per-phase timeouts, bounded retries, a terminal fail state, and a software-initiated restart.

---
 rtl/phy_reset_pkg.sv | 16 +
 rtl/phy_reset_sequencer_status_sync.sv | 27 ++
 rtl/phy_reset_sequencer.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/phy_reset_pkg.sv
// Shared types for the PHY reset sequencer: FSM state encoding and retry width.
package phy_reset_pkg;

  localparam int RETRY_W = 4;

  typedef enum logic [2:0] {
    ST_PLL_RST  = 3'd0,
    ST_PLL_WAIT = 3'd1,
    ST_GT_RST   = 3'd2,
    ST_GT_WAIT  = 3'd3,
    ST_MAC_RST  = 3'd4,
    ST_RUN      = 3'd5,
    ST_FAIL     = 3'd6
  } state_e;

endpackage

// File: rtl/phy_reset_sequencer_status_sync.sv
// Two-flop synchronizer for a single asynchronous status bit.
module status_sync #(
  parameter logic INIT = 1'b0
) (
  input  logic clk,
  input  logic resetn,
  input  logic i_async,
  output logic o_sync
);

  (* ASYNC_REG = "TRUE" *) logic r_meta_p0;
  logic r_sync_p1;

  // Stage 0 captures the raw input, stage 1 gives metastability a cycle to settle.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_meta_p0 <= INIT;
      r_sync_p1 <= INIT;
    end else begin
      r_meta_p0 <= i_async;
      r_sync_p1 <= r_meta_p0;
    end
  end

  assign o_sync = r_sync_p1;

endmodule

// File: rtl/phy_reset_sequencer.sv
// PHY bring-up sequencer: PLL reset, transceiver reset, MAC reset, then link-ready,
// with per-phase timeouts, bounded retries, a terminal fail state and soft restart.
module phy_reset_sequencer
  import phy_reset_pkg::*;
#(
  parameter int PLL_RST_CYCLES = 16,
  parameter int LOCK_TIMEOUT   = 65535,
  parameter int GT_RST_CYCLES  = 16,
  parameter int DONE_TIMEOUT   = 65535,
  parameter int MAC_RST_CYCLES = 8,
  parameter int MAX_RETRIES    = 3,
  parameter int CNT_W          = 16
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               pll_lock,
  input  logic               tx_resetdone,
  input  logic               rx_resetdone,
  input  logic               soft_reset,
  output logic               pll_reset,
  output logic               gt_tx_reset,
  output logic               gt_rx_reset,
  output logic               mac_reset,
  output logic               link_ready,
  output logic               fail,
  output logic [RETRY_W-1:0] retry_count,
  output logic [2:0]         state
);

  localparam logic [CNT_W-1:0]   C_PLL_RST_LAST = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0]   C_LOCK_LAST    = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0]   C_GT_RST_LAST  = CNT_W'(GT_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0]   C_DONE_LAST    = CNT_W'(DONE_TIMEOUT - 1);
  localparam logic [CNT_W-1:0]   C_MAC_RST_LAST = CNT_W'(MAC_RST_CYCLES - 1);
  localparam logic [RETRY_W-1:0] C_MAX_RETRIES  = RETRY_W'(MAX_RETRIES);
  localparam logic [RETRY_W-1:0] C_RETRY_SAT    = '1;
  localparam logic [CNT_W-1:0]   C_CNT_SAT      = '1;

  logic               w_pll_lock_s;
  logic               w_tx_done_s;
  logic               w_rx_done_s;
  state_e             r_state;
  state_e             w_state_next;
  logic [CNT_W-1:0]   r_cnt;
  logic               w_cnt_clr;
  logic               w_timeout;
  logic [RETRY_W-1:0] r_retry;
  logic [RETRY_W-1:0] w_retry_inc;
  logic               r_pll_reset;
  logic               r_gt_reset;
  logic               r_mac_reset;
  logic               r_link_ready;
  logic               r_fail;
  logic               w_pll_reset;
  logic               w_gt_reset;
  logic               w_mac_reset;
  logic               w_link_ready;
  logic               w_fail;

  status_sync #(.INIT(1'b0)) u_sync_lock (
    .clk     (clk),
    .resetn  (resetn),
    .i_async (pll_lock),
    .o_sync  (w_pll_lock_s)
  );

  status_sync #(.INIT(1'b0)) u_sync_tx (
    .clk     (clk),
    .resetn  (resetn),
    .i_async (tx_resetdone),
    .o_sync  (w_tx_done_s)
  );

  status_sync #(.INIT(1'b0)) u_sync_rx (
    .clk     (clk),
    .resetn  (resetn),
    .i_async (rx_resetdone),
    .o_sync  (w_rx_done_s)
  );

  // Next-state decision: soft restart first, then success before timeout per state.
  always_comb begin
    w_state_next = r_state;
    w_timeout    = 1'b0;
    w_retry_inc  = (r_retry == C_RETRY_SAT) ? r_retry : r_retry + RETRY_W'(1);
    if (soft_reset) begin
      w_state_next = ST_PLL_RST;
    end else begin
      case (r_state)
        ST_PLL_RST: begin
          if (r_cnt == C_PLL_RST_LAST) w_state_next = ST_PLL_WAIT;
        end
        ST_PLL_WAIT: begin
          if (w_pll_lock_s) begin
            w_state_next = ST_GT_RST;
          end else if (r_cnt == C_LOCK_LAST) begin
            w_timeout    = 1'b1;
            w_state_next = (w_retry_inc == C_MAX_RETRIES) ? ST_FAIL : ST_PLL_RST;
          end
        end
        ST_GT_RST: begin
          if (r_cnt == C_GT_RST_LAST) w_state_next = ST_GT_WAIT;
        end
        ST_GT_WAIT: begin
          if (!w_pll_lock_s) begin
            w_state_next = ST_PLL_RST;
          end else if (w_tx_done_s && w_rx_done_s) begin
            w_state_next = ST_MAC_RST;
          end else if (r_cnt == C_DONE_LAST) begin
            w_timeout    = 1'b1;
            w_state_next = (w_retry_inc == C_MAX_RETRIES) ? ST_FAIL : ST_GT_RST;
          end
        end
        ST_MAC_RST: begin
          if (r_cnt == C_MAC_RST_LAST) w_state_next = ST_RUN;
        end
        ST_RUN: begin
          if (!w_pll_lock_s) begin
            w_state_next = ST_PLL_RST;
          end else if (!w_tx_done_s || !w_rx_done_s) begin
            w_state_next = ST_GT_RST;
          end
        end
        ST_FAIL: begin
          w_state_next = ST_FAIL;
        end
        default: begin
          w_state_next = ST_PLL_RST;
        end
      endcase
    end
    w_cnt_clr = soft_reset || (w_state_next != r_state);
  end

  // Output decode from the upcoming state so registered outputs track the state register.
  always_comb begin
    w_pll_reset  = 1'b1;
    w_gt_reset   = 1'b1;
    w_mac_reset  = 1'b1;
    w_link_ready = 1'b0;
    w_fail       = 1'b0;
    case (w_state_next)
      ST_PLL_WAIT: w_pll_reset = 1'b0;
      ST_GT_RST:   w_pll_reset = 1'b0;
      ST_GT_WAIT: begin
        w_pll_reset = 1'b0;
        w_gt_reset  = 1'b0;
      end
      ST_MAC_RST: begin
        w_pll_reset = 1'b0;
        w_gt_reset  = 1'b0;
      end
      ST_RUN: begin
        w_pll_reset  = 1'b0;
        w_gt_reset   = 1'b0;
        w_mac_reset  = 1'b0;
        w_link_ready = 1'b1;
      end
      ST_FAIL: w_fail = 1'b1;
      default: ;
    endcase
  end

  // State register and phase counter, cleared on every transition or restart.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= ST_PLL_RST;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_cnt_clr) begin
        r_cnt <= '0;
      end else if (r_cnt != C_CNT_SAT) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  // Retry count: bumps on timeout, clears on restart or once the link is up.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_retry <= '0;
    end else if (soft_reset || (w_state_next == ST_RUN)) begin
      r_retry <= '0;
    end else if (w_timeout) begin
      r_retry <= w_retry_inc;
    end
  end

  // Registered reset and status outputs.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_pll_reset  <= 1'b1;
      r_gt_reset   <= 1'b1;
      r_mac_reset  <= 1'b1;
      r_link_ready <= 1'b0;
      r_fail       <= 1'b0;
    end else begin
      r_pll_reset  <= w_pll_reset;
      r_gt_reset   <= w_gt_reset;
      r_mac_reset  <= w_mac_reset;
      r_link_ready <= w_link_ready;
      r_fail       <= w_fail;
    end
  end

  assign pll_reset   = r_pll_reset;
  assign gt_tx_reset = r_gt_reset;
  assign gt_rx_reset = r_gt_reset;
  assign mac_reset   = r_mac_reset;
  assign link_ready  = r_link_ready;
  assign fail        = r_fail;
  assign retry_count = r_retry;
  assign state       = r_state;

endmodule
